// File: rtl/eth_mii_fcs_tx.sv
// -----------------------------------------------------------------------------
// eth_mii_fcs_tx
//
// Last stage of the video-capture Ethernet TX path. Forwards the upstream frame
// nibble stream (preamble, SFD and payload) to the MII pins with one cycle of
// latency. Appends the IEEE 802.3 CRC-32 FCS directly after the last payload
// nibble and then enforces the inter-frame gap. Frames that start while the
// block is still busy are dropped and flagged.
//
// Ports
//   eth_clk         in   MII TX clock; all logic on its rising edge
//   rst             in   synchronous, active-high reset
//   with_usr        in   frame nibble, low nibble of each byte first
//   with_usr_valid  in   nibble valid; one contiguous high run = one frame
//   eth_txd         out  MII TXD (registered)
//   eth_tx_en       out  MII TX_EN (registered)
//   busy            out  high whenever the FSM is not idle
//   err_overlap     out  1-cycle pulse: frame started during FCS/IFG (dropped)
//   err_odd         out  1-cycle pulse at frame end: odd CRC-covered nibble count
//   frame_cnt       out  frames completed with FCS, wraps at 16 bits
// -----------------------------------------------------------------------------
module eth_mii_fcs_tx #(
    parameter int unsigned PREAMBLE_NIBBLES = 16,
    parameter int unsigned IFG_NIBBLES      = 24
) (
    input  logic        eth_clk,
    input  logic        rst,
    input  logic [3:0]  with_usr,
    input  logic        with_usr_valid,
    output logic [3:0]  eth_txd,
    output logic        eth_tx_en,
    output logic        busy,
    output logic        err_overlap,
    output logic        err_odd,
    output logic [15:0] frame_cnt
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [15:0] PRE_CNT  = 16'(PREAMBLE_NIBBLES);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    localparam int unsigned GAP_W = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_NIBBLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StFcs,
        StIfg,
        StDrop
    } state_e;

    // Reflected CRC-32, four bit-steps per nibble, nibble bit 0 first.
    function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       txd_q, txd_d;
    logic             en_q, en_d;
    logic [15:0]      nib_cnt_q, nib_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [2:0]       fcs_idx_q, fcs_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             valid_q;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             err_odd_q, err_odd_d;
    logic             err_ovl_q, err_ovl_d;
    logic             valid_rise;

    assign valid_rise = with_usr_valid & ~valid_q;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            txd_q       <= 4'h0;
            en_q        <= 1'b0;
            nib_cnt_q   <= 16'd0;
            crc_q       <= CRC_INIT;
            fcs_idx_q   <= 3'd0;
            gap_cnt_q   <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_odd_q   <= 1'b0;
            err_ovl_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            nib_cnt_q   <= nib_cnt_d;
            crc_q       <= crc_d;
            fcs_idx_q   <= fcs_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            valid_q     <= with_usr_valid;
            frame_cnt_q <= frame_cnt_d;
            err_odd_q   <= err_odd_d;
            err_ovl_q   <= err_ovl_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (with_usr_valid) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (!with_usr_valid) begin
                    state_d = StFcs;
                end
            end
            StFcs: begin
                if (fcs_idx_q == 3'd7) begin
                    state_d = StIfg;
                end
            end
            StIfg: begin
                // valid is always low on FCS entry, so valid still high here can
                // only mean an overlapping frame started during FCS/IFG.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = with_usr_valid ? StDrop : StIdle;
                end
            end
            StDrop: begin
                if (!with_usr_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output and datapath next-values
    // -------------------------------------------------------------------------
    always_comb begin
        txd_d       = 4'h0;
        en_d        = 1'b0;
        nib_cnt_d   = nib_cnt_q;
        crc_d       = crc_q;
        fcs_idx_d   = fcs_idx_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_odd_d   = 1'b0;
        err_ovl_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (with_usr_valid) begin
                    txd_d     = with_usr;
                    en_d      = 1'b1;
                    nib_cnt_d = 16'd1;
                    // With no preamble exclusion the very first nibble is covered.
                    crc_d     = (PREAMBLE_NIBBLES == 0) ? crc_fold(CRC_INIT, with_usr) : CRC_INIT;
                end
            end
            StData: begin
                if (with_usr_valid) begin
                    txd_d = with_usr;
                    en_d  = 1'b1;
                    if (nib_cnt_q != CNT_MAX) begin
                        nib_cnt_d = nib_cnt_q + 16'd1;
                    end
                    // Once saturated nib_cnt stays >= PRE_CNT, so folding continues.
                    if (nib_cnt_q >= PRE_CNT) begin
                        crc_d = crc_fold(crc_q, with_usr);
                    end
                end else begin
                    // First FCS nibble goes out on the edge that sees valid fall,
                    // keeping data and FCS back-to-back on TX_EN.
                    txd_d     = ~crc_q[3:0];
                    en_d      = 1'b1;
                    fcs_idx_d = 3'd1;
                    err_odd_d = (nib_cnt_q > PRE_CNT) && (nib_cnt_q[0] != PRE_CNT[0]);
                end
            end
            StFcs: begin
                txd_d     = ~crc_q[{fcs_idx_q, 2'b00} +: 4];
                en_d      = 1'b1;
                err_ovl_d = valid_rise;
                if (fcs_idx_q == 3'd7) begin
                    fcs_idx_d   = 3'd0;
                    gap_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    fcs_idx_d = fcs_idx_q + 3'd1;
                end
            end
            StIfg: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                err_ovl_d = valid_rise;
            end
            StDrop: begin
                // Discard nibbles; outputs stay idle.
            end
            default: begin
            end
        endcase
    end

    assign eth_txd     = txd_q;
    assign eth_tx_en   = en_q;
    assign busy        = (state_q != StIdle);
    assign err_overlap = err_ovl_q;
    assign err_odd     = err_odd_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_eth_mii_fcs_tx.sv
// -----------------------------------------------------------------------------
// tb_eth_mii_fcs_tx
//
// Directed and randomized bench for eth_mii_fcs_tx. Expected wire streams are
// built from a byte-wise table CRC-32 reference model; outputs are recorded
// on the falling clock edge and compared after each frame.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_eth_mii_fcs_tx;

    localparam logic [31:0] POLY = 32'hEDB88320;

    logic        eth_clk;
    logic        rst;
    logic [3:0]  with_usr;
    logic        with_usr_valid;
    logic [3:0]  eth_txd;
    logic        eth_tx_en;
    logic        busy;
    logic        err_overlap;
    logic        err_odd;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] crc_tab [256];

    // Recorded outputs
    logic [3:0] cap_q [$];
    bit         en_log [$];
    bit         busy_log [$];
    int         odd_pulses = 0;
    int         odd_pos    = 0;
    int         ovl_pulses = 0;

    eth_mii_fcs_tx #(
        .PREAMBLE_NIBBLES(16),
        .IFG_NIBBLES     (24)
    ) dut (
        .eth_clk       (eth_clk),
        .rst           (rst),
        .with_usr      (with_usr),
        .with_usr_valid(with_usr_valid),
        .eth_txd       (eth_txd),
        .eth_tx_en     (eth_tx_en),
        .busy          (busy),
        .err_overlap   (err_overlap),
        .err_odd       (err_odd),
        .frame_cnt     (frame_cnt)
    );

    initial eth_clk = 1'b0;
    always #20 eth_clk = ~eth_clk;

    always @(negedge eth_clk) begin
        if (eth_tx_en) cap_q.push_back(eth_txd);
        en_log.push_back(eth_tx_en);
        busy_log.push_back(busy);
        if (err_odd) begin
            odd_pulses++;
            odd_pos = cap_q.size();
        end
        if (err_overlap) ovl_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge eth_clk);
        #1;
    endtask

    task automatic clear_logs();
        cap_q.delete();
        en_log.delete();
        busy_log.delete();
        odd_pulses = 0;
        odd_pos    = 0;
        ovl_pulses = 0;
    endtask

    // Standard software CRC-32 over whole bytes; a trailing half byte is
    // folded bit by bit, low bit first.
    function automatic logic [31:0] ref_fcs(input logic [3:0] pay[$]);
        logic [31:0] r;
        logic [7:0]  b;
        logic        fb;
        r = 32'hFFFFFFFF;
        for (int i = 0; i + 1 < pay.size(); i += 2) begin
            b = {pay[i+1], pay[i]};
            r = (r >> 8) ^ crc_tab[r[7:0] ^ b];
        end
        if (pay.size() % 2 == 1) begin
            for (int k = 0; k < 4; k++) begin
                fb = r[0] ^ pay[pay.size()-1][k];
                r  = r >> 1;
                if (fb) r = r ^ POLY;
            end
        end
        return ~r;
    endfunction

    task automatic make_frame(input logic [3:0] pay[$], output logic [3:0] fr[$]);
        fr.delete();
        for (int i = 0; i < 15; i++) fr.push_back(4'h5);
        fr.push_back(4'hD);
        foreach (pay[i]) fr.push_back(pay[i]);
    endtask

    // Drives one frame; called and returns #1 after a rising edge.
    task automatic drive_frame(input logic [3:0] fr[$]);
        foreach (fr[i]) begin
            with_usr       = fr[i];
            with_usr_valid = 1'b1;
            tick();
        end
        with_usr_valid = 1'b0;
        with_usr       = 4'h0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // Compares the captured TX_EN nibbles against preamble+payload+FCS.
    task automatic check_frame(input string tag, input logic [3:0] pay[$], output logic [31:0] got);
        logic [3:0]  fr[$];
        logic [31:0] fcs;
        int          bad;
        make_frame(pay, fr);
        fcs = ref_fcs(pay);
        for (int k = 0; k < 8; k++) fr.push_back(fcs[4*k +: 4]);
        check({tag, "_len"}, 32'(cap_q.size()), 32'(fr.size()));
        bad = 0;
        foreach (fr[i]) if (i >= cap_q.size() || cap_q[i] !== fr[i]) bad++;
        check({tag, "_nibbles"}, 32'(bad), 32'd0);
        got = 32'd0;
        if (cap_q.size() >= 8) begin
            for (int k = 0; k < 8; k++) got[4*k +: 4] = cap_q[cap_q.size() - 8 + k];
        end
        check({tag, "_fcs"}, got, fcs);
    endtask

    // First TX_EN high index, length of that high run, and low run after it.
    task automatic analyse(output int s, output int h1, output int gap);
        int i = 0;
        h1  = 0;
        gap = 0;
        while (i < en_log.size() && !en_log[i]) i++;
        s = i;
        while (i < en_log.size() && en_log[i]) begin
            h1++;
            i++;
        end
        while (i < en_log.size() && !en_log[i]) begin
            gap++;
            i++;
        end
    endtask

    initial begin
        logic [3:0]  pay_a[$];
        logic [3:0]  pay[$];
        logic [3:0]  fr_a[$];
        logic [3:0]  fr[$];
        logic [31:0] got;
        logic [31:0] c;
        int          s, h1, gap, n;
        logic [15:0] exp_fc;

        for (int t = 0; t < 256; t++) begin
            c = 32'(t);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
            crc_tab[t] = c;
        end
        for (int d = 1; d <= 9; d++) begin
            pay_a.push_back(4'(d));
            pay_a.push_back(4'h3);
        end
        make_frame(pay_a, fr_a);

        // ---- Reset state ------------------------------------------------------
        rst            = 1'b1;
        with_usr       = 4'h0;
        with_usr_valid = 1'b0;
        repeat (3) tick();
        check("rst_tx_en", {31'd0, eth_tx_en}, 32'd0);
        check("rst_txd", {28'd0, eth_txd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {30'd0, err_odd, err_overlap}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        exp_fc = 16'd0;

        // ---- Test 1/2: "123456789" then back-to-back repeat ---------------------
        clear_logs();
        drive_frame(fr_a);
        wait_idle("t1_idle");
        check_frame("t1", pay_a, got);
        check("t1_check_value", got, 32'hCBF43926);
        check("t1_err_odd", 32'(odd_pulses), 32'd0);
        exp_fc++;
        check("t1_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
        // Start the next frame in the first cycle busy is seen low.
        drive_frame(fr_a);
        wait_idle("t2_idle");
        exp_fc++;
        analyse(s, h1, gap);
        check("t2_en_start", 32'(s), 32'd1);
        check("t2_en_high", 32'(h1), 32'd42);
        check("t2_ifg_low", 32'(gap), 32'd24);
        check("t2_busy_last_gap", {31'd0, busy_log[s + 42 + 23]}, 32'd0);
        check("t2_busy_in_gap", {31'd0, busy_log[s + 42 + 22]}, 32'd1);
        check("t2_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        // ---- Test 3: odd payload of 17 nibbles --------------------------------
        clear_logs();
        pay.delete();
        for (int i = 0; i < 17; i++) pay.push_back(4'($urandom_range(0, 15)));
        make_frame(pay, fr);
        drive_frame(fr);
        wait_idle("t3_idle");
        check_frame("t3", pay, got);
        check("t3_err_odd_count", 32'(odd_pulses), 32'd1);
        check("t3_err_odd_pos", 32'(odd_pos), 32'd34);
        exp_fc++;
        check("t3_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        // ---- Random even-length payloads -------------------------------------
        for (int f = 0; f < 4; f++) begin
            clear_logs();
            pay.delete();
            n = 2 * $urandom_range(1, 30);
            for (int i = 0; i < n; i++) pay.push_back(4'($urandom_range(0, 15)));
            make_frame(pay, fr);
            drive_frame(fr);
            wait_idle("rnd_idle");
            check_frame("rnd", pay, got);
            check("rnd_err_odd", 32'(odd_pulses), 32'd0);
            exp_fc++;
        end
        check("rnd_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        // ---- Test 4a: long frame raised 5 cycles into the IFG -----------------
        clear_logs();
        drive_frame(fr_a);
        n = 0;
        while (eth_tx_en === 1'b0 && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (eth_tx_en && n < 100) begin
            tick();
            n++;
        end
        check("t4_en_fell", {31'd0, eth_tx_en}, 32'd0);
        repeat (5) tick();
        pay.delete();
        for (int i = 0; i < 40; i++) pay.push_back(4'($urandom_range(0, 15)));
        drive_frame(pay);
        wait_idle("t4_idle");
        exp_fc++;
        check_frame("t4", pay_a, got);
        check("t4_overlap", 32'(ovl_pulses), 32'd1);
        check("t4_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        // ---- Test 4b: short frame raised during FCS; IFG length unchanged -----
        clear_logs();
        drive_frame(fr_a);
        tick();
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(4'($urandom_range(0, 15)));
        drive_frame(pay);
        wait_idle("t4b_idle");
        drive_frame(fr_a);
        wait_idle("t4b_idle2");
        exp_fc += 16'd2;
        analyse(s, h1, gap);
        check("t4b_overlap", 32'(ovl_pulses), 32'd1);
        check("t4b_en_high", 32'(h1), 32'd42);
        check("t4b_ifg_low", 32'(gap), 32'd24);
        check("t4b_total", 32'(cap_q.size()), 32'd84);
        check("t4b_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        // ---- Test 5: reset at data nibble 20 ----------------------------------
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            with_usr       = fr_a[i];
            with_usr_valid = 1'b1;
            tick();
        end
        with_usr_valid = 1'b0;
        rst            = 1'b1;
        tick();
        check("t5_en_after_rst", {31'd0, eth_tx_en}, 32'd0);
        check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (40) tick();
        exp_fc = 16'd0;
        check("t5_no_fcs", 32'(cap_q.size()), 32'd20);
        check("t5_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        clear_logs();
        drive_frame(fr_a);
        wait_idle("t5_idle");
        check_frame("t5_replay", pay_a, got);
        check("t5_replay_value", got, 32'hCBF43926);
        exp_fc++;
        check("t5_replay_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        // ---- Test 6: preamble-only frame --------------------------------------
        clear_logs();
        pay.delete();
        make_frame(pay, fr);
        drive_frame(fr);
        wait_idle("t6_idle");
        check_frame("t6", pay, got);
        check("t6_zero_fcs", got, 32'h00000000);
        check("t6_err_odd", 32'(odd_pulses), 32'd0);
        exp_fc++;
        check("t6_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
